// File: rtl/cpu_defs.sv
// Constants and types shared by every pipeline stage of the MIPS core.
// The F/D pipeline register layout lives here so that D/E can reuse fd_reg.
package cpu_defs;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_TOP    = 32'h0000_6FFC;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } fd_t;

  // Fetch address error: misaligned word, or outside the instruction memory window.
  function automatic logic fetch_adel(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the IM (slave).
interface fetch_stage_if;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;

  modport master (output i_inst_addr, input  i_inst_rdata);
  modport slave  (input  i_inst_addr, output i_inst_rdata);
endinterface

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: reset, enable (low = stall), flush to a bubble.
// On flush the PC tag is either the handler entry or the incoming PC.
module fd_reg
  import cpu_defs::*;
#(
  parameter logic [31:0] RST_PC   = RESET_PC,
  parameter logic [31:0] FLUSH_PC = EXC_ENTRY
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic flush,
  input  logic flush_pc_sel,
  input  fd_t  d,
  output fd_t  q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '{instr: NOP, pc: RST_PC, exc: EXC_NONE, bd: 1'b0};
    end else if (en) begin
      if (flush)
        q <= '{instr: NOP, pc: (flush_pc_sel ? FLUSH_PC : d.pc), exc: EXC_NONE, bd: 1'b0};
      else
        q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// F stage: PC register, AdEL detection, and the F/D register with
// reset > req > stall > eret > normal update priority.
module fetch_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] P_RESET_PC  = RESET_PC,
  parameter logic [31:0] P_EXC_ENTRY = EXC_ENTRY,
  parameter logic [31:0] P_IM_BASE   = IM_BASE,
  parameter logic [31:0] P_IM_TOP    = IM_TOP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         nextPC,
  input  logic                stall,
  input  logic                req,
  input  logic                eret_D,
  input  logic                branch_D,
  fetch_stage_if.master       imem,
  output logic [31:0]         PC_F,
  output logic [31:0]         PC_D,
  output logic [31:0]         instr_D,
  output logic [4:0]          ExcCode_D,
  output logic                BD_D
);

  logic adel_F;
  logic advance;
  fd_t  fd_in;
  fd_t  fd_q;

  assign imem.i_inst_addr = PC_F;
  assign adel_F = fetch_adel(PC_F, P_IM_BASE, P_IM_TOP);

  // A faulting fetch still moves into D; the bubble word and ExcCode carry the fault.
  assign fd_in = '{instr: (adel_F ? NOP : imem.i_inst_rdata),
                   pc:    PC_F,
                   exc:   (adel_F ? EXC_ADEL : EXC_NONE),
                   bd:    branch_D};

  // req overrides stall; eret only squashes when the pipe actually moves.
  assign advance = req | ~stall;

  always_ff @(posedge clk) begin
    if (reset)
      PC_F <= P_RESET_PC;
    else if (advance)
      PC_F <= nextPC;
  end

  fd_reg #(
    .RST_PC   (P_RESET_PC),
    .FLUSH_PC (P_EXC_ENTRY)
  ) u_fd_reg (
    .clk          (clk),
    .reset        (reset),
    .en           (advance),
    .flush        (req | eret_D),
    .flush_pc_sel (req),
    .d            (fd_in),
    .q            (fd_q)
  );

  assign PC_D      = fd_q.pc;
  assign instr_D   = fd_q.instr;
  assign ExcCode_D = fd_q.exc;
  assign BD_D      = fd_q.bd;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a random run
// against a cycle-level reference model of the F stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret_D, branch_D;
  logic [31:0] nextPC;
  logic [31:0] PC_F, PC_D, instr_D;
  logic [4:0]  ExcCode_D;
  logic        BD_D;

  int checks = 0;
  int errors = 0;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk(clk), .reset(reset), .nextPC(nextPC), .stall(stall), .req(req),
    .eret_D(eret_D), .branch_D(branch_D), .imem(imem),
    .PC_F(PC_F), .PC_D(PC_D), .instr_D(instr_D), .ExcCode_D(ExcCode_D), .BD_D(BD_D)
  );

  always #5 clk = ~clk;

  // Instruction memory: either a fixed word or an address-derived pattern.
  logic        fixed_mode = 1'b1;
  logic [31:0] fixed_word = 32'h2408_0001;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return fixed_mode ? fixed_word : ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234);
  endfunction

  assign imem.i_inst_rdata = mem_word(imem.i_inst_addr);

  // Reference model state
  logic [31:0] m_pcf, m_pcd, m_instr;
  logic [4:0]  m_exc;
  logic        m_bd;

  // Apply one clock edge to both DUT and model, then settle past the edge.
  task automatic tick();
    logic        adel;
    logic [31:0] pcf, pcd, ins;
    logic [4:0]  exc;
    logic        bd;
    adel = (m_pcf[1:0] != 2'b00) || (m_pcf < 32'h3000) || (m_pcf > 32'h6FFC);
    pcf = m_pcf; pcd = m_pcd; ins = m_instr; exc = m_exc; bd = m_bd;
    if (reset) begin
      pcf = 32'h3000; pcd = 32'h3000; ins = 0; exc = 0; bd = 0;
    end else if (req) begin
      pcf = nextPC; pcd = 32'h4180; ins = 0; exc = 0; bd = 0;
    end else if (stall) begin
      // everything holds
    end else if (eret_D) begin
      pcd = m_pcf; pcf = nextPC; ins = 0; exc = 0; bd = 0;
    end else begin
      pcd = m_pcf; ins = adel ? 32'h0 : mem_word(m_pcf);
      exc = adel ? 5'd4 : 5'd0; bd = branch_D; pcf = nextPC;
    end
    @(posedge clk);
    m_pcf = pcf; m_pcd = pcd; m_instr = ins; m_exc = exc; m_bd = bd;
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; req = 0; eret_D = 0; branch_D = 0; nextPC = m_pcf + 4;
  endtask

  task automatic test_reset();
    m_pcf = 32'hDEAD_BEEF; m_pcd = 32'hDEAD_BEEF; m_instr = 0; m_exc = 0; m_bd = 0;
    reset = 1; stall = 0; req = 0; eret_D = 0; branch_D = 0; nextPC = 32'h1234_5678;
    tick();
    checks++;
    if ({PC_F, PC_D, instr_D, ExcCode_D, BD_D} !== {32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got PC_F=%h PC_D=%h instr_D=%h exc=%0d bd=%b", PC_F, PC_D, instr_D, ExcCode_D, BD_D);
    end
    checks++;
    if (imem.i_inst_addr !== 32'h3000) begin
      errors++;
      $display("FAIL reset_addr: got %h want 00003000", imem.i_inst_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'h3004, 32'h3008, 32'h300C};
    fixed_mode = 1;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      tick();
      checks++;
      if (PC_F !== exp_pc[i] || PC_D !== exp_pc[i] - 4 || instr_D !== 32'h2408_0001) begin
        errors++;
        $display("FAIL seq[%0d]: got PC_F=%h PC_D=%h instr_D=%h want PC_F=%h PC_D=%h instr_D=24080001",
                 i, PC_F, PC_D, instr_D, exp_pc[i], exp_pc[i] - 4);
      end
    end
  endtask

  // Reset then two free edges leaves PC_F at 3008 for the stall test.
  task automatic test_stall();
    idle_inputs(); reset = 1; tick();
    idle_inputs(); tick();
    idle_inputs(); tick();
    for (int i = 0; i < 2; i++) begin
      idle_inputs(); stall = 1; nextPC = 32'h5000;
      tick();
      checks++;
      if (PC_F !== 32'h3008 || PC_D !== 32'h3004 || instr_D !== 32'h2408_0001) begin
        errors++;
        $display("FAIL stall[%0d]: got PC_F=%h PC_D=%h instr_D=%h want 3008/3004/24080001", i, PC_F, PC_D, instr_D);
      end
    end
    idle_inputs(); tick();
    checks++;
    if (PC_F !== 32'h300C || PC_D !== 32'h3008) begin
      errors++;
      $display("FAIL stall_release: got PC_F=%h PC_D=%h want 300c/3008", PC_F, PC_D);
    end
  endtask

  task automatic test_adel();
    logic [31:0] bad [3] = '{32'h3002, 32'h7000, 32'h2FFC};
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); nextPC = bad[i]; tick();
      idle_inputs(); tick();
      checks++;
      if (instr_D !== 32'h0 || ExcCode_D !== 5'd4 || PC_D !== bad[i]) begin
        errors++;
        $display("FAIL adel[%h]: got instr_D=%h exc=%0d PC_D=%h want 0/4/%h", bad[i], instr_D, ExcCode_D, PC_D, bad[i]);
      end
    end
    // Boundary: highest legal word must not fault.
    idle_inputs(); nextPC = 32'h6FFC; tick();
    idle_inputs(); tick();
    checks++;
    if (ExcCode_D !== 5'd0 || instr_D !== 32'h2408_0001 || PC_D !== 32'h6FFC) begin
      errors++;
      $display("FAIL adel_top: got instr_D=%h exc=%0d PC_D=%h want 24080001/0/6ffc", instr_D, ExcCode_D, PC_D);
    end
  endtask

  task automatic test_req();
    idle_inputs(); branch_D = 1; tick();
    idle_inputs(); stall = 1; req = 1; branch_D = 1; nextPC = 32'h4180; tick();
    checks++;
    if (PC_F !== 32'h4180 || instr_D !== 32'h0 || PC_D !== 32'h4180 || BD_D !== 1'b0 || ExcCode_D !== 5'd0) begin
      errors++;
      $display("FAIL req: got PC_F=%h instr_D=%h PC_D=%h BD_D=%b exc=%0d want 4180/0/4180/0/0",
               PC_F, instr_D, PC_D, BD_D, ExcCode_D);
    end
  endtask

  task automatic test_branch_eret();
    logic [31:0] pc_before;
    idle_inputs(); nextPC = 32'h3000; tick();
    idle_inputs(); branch_D = 1; tick();
    checks++;
    if (BD_D !== 1'b1 || PC_D !== 32'h3000) begin
      errors++;
      $display("FAIL branch_bd: got BD_D=%b PC_D=%h want 1/3000", BD_D, PC_D);
    end
    // stall together with eret: stall wins
    idle_inputs(); stall = 1; eret_D = 1; nextPC = 32'h3010; pc_before = PC_F; tick();
    checks++;
    if (PC_F !== pc_before || BD_D !== 1'b1) begin
      errors++;
      $display("FAIL eret_stalled: got PC_F=%h BD_D=%b want %h/1", PC_F, BD_D, pc_before);
    end
    idle_inputs(); eret_D = 1; nextPC = 32'h3010; tick();
    checks++;
    if (PC_F !== 32'h3010 || instr_D !== 32'h0 || PC_D !== pc_before || BD_D !== 1'b0) begin
      errors++;
      $display("FAIL eret: got PC_F=%h instr_D=%h PC_D=%h BD_D=%b want 3010/0/%h/0", PC_F, instr_D, PC_D, BD_D, pc_before);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs(); tick();
    idle_inputs(); stall = 1; tick();
    idle_inputs(); stall = 1; req = 1; reset = 1; nextPC = 32'h4180; tick();
    checks++;
    if ({PC_F, PC_D, instr_D, ExcCode_D, BD_D} !== {32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_stall: got PC_F=%h PC_D=%h instr_D=%h exc=%0d bd=%b", PC_F, PC_D, instr_D, ExcCode_D, BD_D);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    fixed_mode = 0;
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(63) == 0);
      req      = ($urandom_range(15) == 0);
      stall    = ($urandom_range(3) == 0);
      eret_D   = ($urandom_range(7) == 0);
      branch_D = ($urandom_range(3) == 0);
      case ($urandom_range(9))
        0:       nextPC = $urandom;
        1:       nextPC = 32'h3000 + ($urandom_range(32'h3FFF) & 32'hFFFF_FFFC) + $urandom_range(3);
        2:       nextPC = 32'h4180;
        default: nextPC = m_pcf + 4;
      endcase
      tick();
      checks++;
      if ({PC_F, PC_D, instr_D, ExcCode_D, BD_D, imem.i_inst_addr} !==
          {m_pcf, m_pcd, m_instr, m_exc, m_bd, m_pcf}) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random[%0d]: got %h %h %h %0d %b want %h %h %h %0d %b", i,
                   PC_F, PC_D, instr_D, ExcCode_D, BD_D, m_pcf, m_pcd, m_instr, m_exc, m_bd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_adel();
    test_req();
    test_branch_eret();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
